// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start/data/stop framing, ready/valid handoff and
// error pulses. Define UART_RX_PARITY_EN to add an even-parity bit and parity_err_o.
module uart_rx_deser #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  axi_aclk_i,
    input  logic                  axi_aresetn_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err_o,
`endif
    output logic                  busy_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state, state_n;
    logic                    rx_meta, rx_s, rx_d;
    logic [2:0]              settle;
    logic                    fall_edge;
    logic [BAUD_W-1:0]       baud_cnt, baud_n;
    logic                    baud_tick;
    logic [BIT_W-1:0]        bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic                    valid_n;
    logic                    deliver;
    logic                    frame_err_n, overrun_n;
`ifdef UART_RX_PARITY_EN
    logic                    parity_bit, parity_bit_n;
    logic                    parity_err_n;
`endif

    // The synchronizer resets high, so settle keeps those fake-idle values from
    // being mistaken for a falling edge when the line is already low at release.
    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            settle  <= 3'b000;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            settle  <= {settle[1:0], 1'b1};
        end
    end

    assign fall_edge = settle[2] && rx_d && !rx_s;
    assign baud_tick = (baud_cnt == '0);
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_n     = state;
        baud_n      = baud_tick ? baud_cnt : baud_cnt - BAUD_W'(1);
        bit_n       = bit_cnt;
        shift_n     = shift_reg;
        deliver     = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_n = parity_bit;
        parity_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_n = START;
                    baud_n  = BAUD_HALF;
                    bit_n   = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        baud_n  = BAUD_FULL;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_n                 = shift_reg >> 1;
                    shift_n[DATA_WIDTH-1]   = rx_s;
                    baud_n                  = BAUD_FULL;
                    bit_n                   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    parity_bit_n = rx_s;
                    baud_n       = BAUD_FULL;
                    state_n      = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_n = IDLE;
                    // A bad stop bit outranks a parity mismatch.
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shift_reg) != parity_bit) begin
                        parity_err_n = 1'b1;
`endif
                    end else if (!rx_valid_o || rx_ready_i) begin
                        deliver = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_n  = rx_data_o;
        valid_n = rx_valid_o;
        if (deliver) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
        end else if (rx_valid_o && rx_ready_i) begin
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_n;
            bit_cnt      <= bit_n;
            shift_reg    <= shift_n;
            rx_data_o    <= data_n;
            rx_valid_o   <= valid_n;
            frame_err_o  <= frame_err_n;
            overrun_o    <= overrun_n;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= parity_bit_n;
            parity_err_o <= parity_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser (CLKS_PER_BIT=16, DATA_WIDTH=8) with a
// byte scoreboard popped on each accepted rx_valid_o/rx_ready_i handshake.
module tb_uart_rx_deser;

    localparam int CPB = 16;
    localparam int DW  = 8;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] exp_q[$];
    int            accepted     = 0;
    int            valid_cycles = 0;
    int            ferr_cycles  = 0;
    int            ovr_cycles   = 0;
    int            perr_cycles  = 0;
    int            busy_cycles  = 0;
    int            valid_rise   = 0;
    logic          prev_valid   = 1'b0;
    logic [DW-1:0] prev_data    = '0;

    uart_rx_deser #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .axi_aclk_i   (clk),
        .axi_aresetn_i(rst_n),
        .rx_i         (rx),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled on falling edges.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] data, input logic stop_bit,
                                  input logic par_bit);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < DW; i++) begin
            rx = data[i];
            wait_clks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_clks(CPB);
`else
        if (par_bit === 1'bz) $display("[TB] unreachable");
`endif
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)  valid_cycles++;
            if (frame_err) ferr_cycles++;
            if (overrun)   ovr_cycles++;
            if (busy)      busy_cycles++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cycles++;
`endif
            if (rx_valid && !prev_valid) valid_rise = cyc;
            if (rx_valid && prev_valid) check_output("data_stable", rx_data, prev_data);
            if (rx_valid && rx_ready) begin
                check_output("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_output("rx_data", rx_data, exp_q.pop_front());
                accepted++;
            end
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
    end

    initial begin
        int acc0, vc0, fe0, ov0, pe0, bc0, c0, lat;
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        wait_clks(4);
        check_output("reset_valid", rx_valid, 0);
        check_output("reset_data", rx_data, 0);
        check_output("reset_ferr", frame_err, 0);
        check_output("reset_ovr", overrun, 0);
        check_output("reset_busy", busy, 0);
        rst_n = 1'b1;
        wait_clks(10);

        $display("[TB] single byte 0xA5");
        acc0 = accepted; vc0 = valid_cycles; fe0 = ferr_cycles; ov0 = ovr_cycles;
        exp_q.push_back(8'hA5);
        c0 = cyc;
        apply_stimulus(8'hA5, 1'b1, ^8'hA5);
        wait_clks(20);
        lat = valid_rise - c0;
        check_output("a5_accepted", accepted - acc0, 1);
        check_output("a5_valid_one_cycle", valid_cycles - vc0, 1);
        check_output("a5_no_ferr", ferr_cycles - fe0, 0);
        check_output("a5_no_ovr", overrun ? 1 : ovr_cycles - ov0, 0);
        check_output("a5_latency_ok", (lat >= 155 && lat <= 157), 1);

        $display("[TB] start-bit glitch");
        acc0 = accepted; fe0 = ferr_cycles; bc0 = busy_cycles;
        rx = 1'b0;
        wait_clks(5);
        rx = 1'b1;
        wait_clks(40);
        check_output("glitch_went_busy", busy_cycles > bc0, 1);
        check_output("glitch_idle", busy, 0);
        check_output("glitch_no_valid", accepted - acc0, 0);
        check_output("glitch_no_ferr", ferr_cycles - fe0, 0);

        $display("[TB] framing error then recovery");
        acc0 = accepted; fe0 = ferr_cycles;
        apply_stimulus(8'h3C, 1'b0, ^8'h3C);
        wait_clks(20);
        check_output("ferr_one_pulse", ferr_cycles - fe0, 1);
        check_output("ferr_no_valid", accepted - acc0, 0);
        check_output("ferr_valid_low", rx_valid, 0);
        exp_q.push_back(8'h81);
        apply_stimulus(8'h81, 1'b1, ^8'h81);
        wait_clks(20);
        check_output("recover_accepted", accepted - acc0, 1);

        $display("[TB] overrun");
        rx_ready = 1'b0;
        acc0 = accepted; ov0 = ovr_cycles;
        exp_q.push_back(8'h11);
        apply_stimulus(8'h11, 1'b1, ^8'h11);
        wait_clks(20);
        check_output("ovr_first_valid", rx_valid, 1);
        apply_stimulus(8'h22, 1'b1, ^8'h22);
        wait_clks(20);
        check_output("ovr_one_pulse", ovr_cycles - ov0, 1);
        check_output("ovr_data_kept", rx_data, 8'h11);
        check_output("ovr_still_valid", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clks(2);
        check_output("ovr_consumed", accepted - acc0, 1);
        check_output("ovr_valid_clear", rx_valid, 0);

        $display("[TB] reset mid-frame with low line");
        acc0 = accepted;
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clks(CPB);
        end
        rx    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", rx_valid, 0);
        check_output("midrst_busy", busy, 0);
        wait_clks(10);
        rst_n = 1'b1;
        wait_clks(100);
        check_output("lowline_idle", busy, 0);
        rx = 1'b1;
        wait_clks(20);
        exp_q.push_back(8'h5A);
        apply_stimulus(8'h5A, 1'b1, ^8'h5A);
        wait_clks(20);
        check_output("midrst_only_5a", accepted - acc0, 1);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        acc0 = accepted; pe0 = perr_cycles;
        apply_stimulus(8'h07, 1'b1, 1'b0);
        wait_clks(20);
        check_output("par_err_pulse", perr_cycles - pe0, 1);
        check_output("par_err_no_valid", accepted - acc0, 0);
        exp_q.push_back(8'h07);
        apply_stimulus(8'h07, 1'b1, 1'b1);
        wait_clks(20);
        check_output("par_ok_accepted", accepted - acc0, 1);
        check_output("par_ok_no_err", perr_cycles - pe0, 1);
`else
        pe0 = perr_cycles;
        check_output("no_parity_pulses", pe0, 0);
`endif

        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 868: clocks per bit period (115200 bps at 100 MHz); legal range 4..65535.
REQ-003 axi_aclk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 axi_aresetn_i  in  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  in  1  serial line, asynchronous to clock, idle high.
REQ-006 rx_data_o  out  DATA_WIDTH  received byte, LSB received first.
REQ-007 rx_valid_o  out  1  rx_data_o holds an unconsumed byte.
REQ-008 rx_ready_i  in  1  consumer (RX FIFO) accepts byte when high with rx_valid_o.
REQ-009 frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun_o  out  1  one-cycle pulse: byte completed while previous byte still unconsumed.
REQ-011 busy_o  out  1  high in any state other than IDLE.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (rx_s) and its 1-cycle delayed copy.
REQ-013 States SHALL be IDLE, START, DATA, STOP (plus PARITY per REQ-028).
REQ-014 IDLE->START on falling edge of rx_s (previous 1, current 0); bit counter cleared, baud counter loaded.
REQ-015 START: after CLKS_PER_BIT/2 (integer division) clocks sample rx_s; 0 -> DATA with baud counter reloaded; 1 -> IDLE (glitch reject, no output, no error).
REQ-016 DATA: every CLKS_PER_BIT clocks sample rx_s into the shift register LSB-first; after DATA_WIDTH samples -> STOP.
REQ-017 STOP: after CLKS_PER_BIT clocks sample rx_s; 1 -> deliver byte per REQ-018, then IDLE; 0 -> frame_err_o pulse for one cycle, byte discarded, then IDLE.
REQ-018 Delivery: if rx_valid_o is low, or rx_valid_o and rx_ready_i are both high in the same cycle, load rx_data_o and set rx_valid_o the cycle after the stop sample; otherwise pulse overrun_o, keep the old byte, and discard the new one.
REQ-019 rx_valid_o SHALL clear the cycle after rx_valid_o && rx_ready_i, unless a new byte is loaded in that same cycle.
REQ-020 rx_data_o SHALL stay stable while rx_valid_o is high.
REQ-021 A continuous low line after a frame error SHALL NOT start a new frame until rx_s returns high and falls again.
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap; the bit counter SHALL be wide enough for DATA_WIDTH.
REQ-023 Latency: the falling edge of rx_i to rx_valid_o is 2 + 1 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 clocks, within ±1 clock for asynchronous edge alignment.

Reset
REQ-024 While axi_aresetn_i is low: state IDLE, synchronizer flops 1, rx_data_o 0, rx_valid_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no partial output; after release, a line that is already low SHALL NOT start a frame until a high-to-low edge occurs.

Configuration
REQ-026 Macro UART_RX_PARITY_EN SHALL compile in even-parity checking.
REQ-027 With the macro defined, the block SHALL add output parity_err_o (1 bit, one-cycle pulse, reset 0).
REQ-028 With the macro defined, DATA SHALL go to PARITY, which samples after CLKS_PER_BIT clocks and then goes to STOP; a mismatch against even parity of the data bits pulses parity_err_o at stop-sample time and discards the byte. A stop error takes precedence: only frame_err_o pulses.
REQ-029 Without the macro, the frame is start + DATA_WIDTH + stop, and neither parity_err_o nor the PARITY state exists.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8)
REQ-030 Send 0xA5 with valid stop, rx_ready_i=1 -> rx_data_o=0xA5, rx_valid_o high for exactly 1 cycle, no error pulses.
REQ-031 Pulse rx_i low for 5 clocks from idle -> START returns to IDLE, rx_valid_o stays 0, frame_err_o stays 0.
REQ-032 Send 0x3C with stop bit 0 -> frame_err_o one pulse, rx_valid_o stays 0; then send 0x81 after line high -> rx_data_o=0x81.
REQ-033 rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, overrun_o one pulse at second stop; rx_ready_i=1 -> 0x11 consumed, rx_valid_o clears.
REQ-034 Reset asserted at bit 4 of 0xFF with line then held low -> no output; release reset, hold low 100 clocks, then high and send 0x5A -> only 0x5A delivered.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err_o one pulse, no rx_valid_o; send 0x07 with parity bit 1 -> rx_data_o=0x07.
